// File: rtl/sdram_p2_frontend.sv
// Host-side front end for the SDRAM controller's 64-bit burst port.
// Splits host reads into bursts of at most MAX_BURST words. A burst is issued
// only when the read FIFO is guaranteed to have room for every word of it,
// because the controller's acks cannot be stalled. Writes are single-word.
module sdram_p2_frontend #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [7:0]  cmd_ds,
  input  logic [63:0] cmd_wdata,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [63:0] rd_data,
  output logic        rd_last,
  output logic        mem_req,
  input  logic        mem_busy,
  output logic        mem_we,
  output logic [7:0]  mem_burstcnt,
  output logic [23:0] mem_a,
  output logic [7:0]  mem_ds,
  output logic [63:0] mem_d,
  input  logic [63:0] mem_q,
  input  logic        mem_ack
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT} state_t;
  state_t state;

  logic [23:0] rd_addr;      // address of the next word to be acked
  logic [7:0]  remaining;    // words of the command not yet requested
  logic [7:0]  outstanding;  // words requested but not yet acked
  logic        wr_skip;      // first WR_WAIT cycle: controller busy not yet valid

  logic [64:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic [64:0] head;
  logic [15:0] free_slots;
  logic [7:0]  chunk;
  logic        rd_go, push, pop, ack_last;
  logic        unused_bits;

  assign unused_bits = &{1'b0, cmd_addr[2:0]};

  assign count      = wr_ptr - rd_ptr;
  assign free_slots = 16'(FIFO_DEPTH) - 16'(count);
  assign chunk      = (remaining > 8'(MAX_BURST)) ? 8'(MAX_BURST) : remaining;
  assign rd_go      = !mem_busy && (free_slots >= {8'd0, chunk});
  assign push       = mem_ack && (state == RD_WAIT);
  assign pop        = rd_valid && rd_ready;
  assign ack_last   = (outstanding == 8'd1) && (remaining == 8'd0);

  // First-word fall-through head; rd_last is gated so an empty FIFO never shows it
  assign head     = fifo_mem[rd_ptr[AW-1:0]];
  assign rd_valid = (count != '0);
  assign rd_data  = head[63:0];
  assign rd_last  = rd_valid && head[64];

  // FIFO storage: words tagged with their end-of-command flag
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {ack_last, mem_q};
  end

  // FIFO pointers; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // The credit check makes an overflowing ack impossible
  always_ff @(posedge clk) begin
    if (!reset && push && !pop) assert (count != FULL_CNT);
  end

  // Command FSM with registered handshake and controller outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cmd_ready    <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_burstcnt <= 8'd0;
      mem_a        <= 24'd0;
      mem_ds       <= 8'd0;
      mem_d        <= 64'd0;
      rd_addr      <= 24'd0;
      remaining    <= 8'd0;
      outstanding  <= 8'd0;
      wr_skip      <= 1'b0;
    end else begin
      mem_req   <= 1'b0;
      cmd_ready <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            if (cmd_we) begin
              mem_a     <= {cmd_addr[23:3], 3'b000};
              mem_ds    <= cmd_ds;
              mem_d     <= cmd_wdata;
              cmd_ready <= 1'b0;
              state     <= WR_ISSUE;
            end else if (cmd_len != 8'd0) begin
              rd_addr   <= {cmd_addr[23:3], 3'b000};
              remaining <= cmd_len;
              cmd_ready <= 1'b0;
              state     <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          if (rd_go) begin
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_burstcnt <= chunk;
            mem_a        <= rd_addr;
            outstanding  <= chunk;
            remaining    <= remaining - chunk;
            state        <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_ack) begin
            rd_addr     <= rd_addr + 24'd8;
            outstanding <= outstanding - 8'd1;
            if (outstanding == 8'd1) begin
              if (remaining != 8'd0) begin
                state <= RD_ISSUE;
              end else begin
                state     <= IDLE;
                cmd_ready <= 1'b1;
              end
            end
          end
        end
        WR_ISSUE: begin
          if (!mem_busy) begin
            mem_req      <= 1'b1;
            mem_we       <= 1'b1;
            mem_burstcnt <= 8'd1;
            wr_skip      <= 1'b1;
            state        <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (wr_skip) begin
            wr_skip <= 1'b0;
          end else if (!mem_busy) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_p2_frontend.sv
// Scoreboard bench for sdram_p2_frontend: a reference model computes expected
// controller requests and read words per command; monitors compare on output.
module tb_sdram_p2_frontend;
  localparam int FD = 16;
  localparam int MB = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [23:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0, cmd_ds = '0;
  logic [63:0] cmd_wdata = '0;
  logic        cmd_ready, rd_valid, rd_last;
  logic        rd_ready = 1'b0;
  logic [63:0] rd_data;
  logic        mem_req, mem_we;
  logic        mem_busy = 1'b0, mem_ack = 1'b0;
  logic [7:0]  mem_burstcnt, mem_ds;
  logic [23:0] mem_a;
  logic [63:0] mem_d;
  logic [63:0] mem_q = '0;

  sdram_p2_frontend #(.FIFO_DEPTH(FD), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_ds(cmd_ds), .cmd_wdata(cmd_wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .mem_req(mem_req), .mem_busy(mem_busy), .mem_we(mem_we),
    .mem_burstcnt(mem_burstcnt), .mem_a(mem_a), .mem_ds(mem_ds), .mem_d(mem_d),
    .mem_q(mem_q), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory contents (both views start from the same pattern)
  function automatic logic [63:0] init_word(logic [20:0] w);
    return {w, 11'h5A5, ~w, 11'h3C3};
  endfunction

  function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] nw, logic [7:0] ds);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (ds[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  logic [63:0] ref_mem [logic [20:0]];
  logic [63:0] ctl_mem [logic [20:0]];

  function automatic logic [63:0] ref_get(logic [20:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction
  function automatic logic [63:0] ctl_get(logic [20:0] w);
    return ctl_mem.exists(w) ? ctl_mem[w] : init_word(w);
  endfunction

  // ---------------- scoreboard queues
  typedef struct {
    logic        we;
    logic [7:0]  cnt;
    logic [23:0] a;
    logic [7:0]  ds;
    logic [63:0] d;
  } req_t;
  req_t        exp_req [$];
  logic [64:0] exp_rd  [$];

  // Reference model: derive every request and word a command must produce
  task automatic model_cmd(bit we, logic [23:0] addr, logic [7:0] len,
                           logic [7:0] ds, logic [63:0] wd);
    logic [23:0] base;
    req_t r;
    int n;
    base = {addr[23:3], 3'b000};
    if (we) begin
      r = '{we: 1'b1, cnt: 8'd1, a: base, ds: ds, d: wd};
      exp_req.push_back(r);
      ref_mem[base[23:3]] = merge(ref_get(base[23:3]), wd, ds);
    end else begin
      for (int i = 0; i < int'(len); i++)
        exp_rd.push_back({(i == int'(len) - 1), ref_get(base[23:3] + 21'(i))});
      for (int off = 0; off < int'(len); off += MB) begin
        n = (int'(len) - off > MB) ? MB : int'(len) - off;
        r = '{we: 1'b0, cnt: 8'(n), a: base + 24'(off * 8), ds: 8'd0, d: 64'd0};
        exp_req.push_back(r);
      end
    end
  endtask

  task automatic send_cmd(bit we, logic [23:0] addr, logic [7:0] len,
                          logic [7:0] ds, logic [63:0] wd);
    int t;
    t = 0;
    model_cmd(we, addr, len, ds, wd);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len;
    cmd_ds = ds; cmd_wdata = wd;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      if (++t > 3000) begin
        n_tests++; n_fail++;
        $display("FAIL cmd_accept: cmd_ready still 0 after %0d cycles, required 1", t);
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((exp_rd.size() != 0 || exp_req.size() != 0 || !cmd_ready || mem_busy) && t < 6000);
    n_tests++;
    if (t >= 6000) begin
      n_fail++;
      $display("FAIL %s_drain: %0d words / %0d requests still pending, required 0", name,
               exp_rd.size(), exp_req.size());
    end
  endtask

  // ---------------- controller model
  int acks_done = 0;
  int wr_busy_force = 0;
  int late_ack_req = 0, late_ack_seen = 0;

  task automatic ctl_tick(output bit rst);
    @(posedge clk); #2;
    mem_ack = 1'b0;
    rst = reset;
  endtask

  task automatic serve();
    logic        we;
    logic [7:0]  cnt, ds;
    logic [23:0] a;
    logic [63:0] d;
    bit          rst;
    int          nb, g;
    we = mem_we; cnt = mem_burstcnt; a = mem_a; ds = mem_ds; d = mem_d;
    nb = (wr_busy_force > 0) ? wr_busy_force : $urandom_range(1, 6);
    ctl_tick(rst);
    if (rst) return;
    mem_busy = 1'b1;
    if (we) begin
      for (int i = 0; i < nb; i++) begin
        if (i > 0) begin
          ctl_tick(rst);
          if (rst) begin mem_busy = 1'b0; return; end
        end
        chk("wr_hold_a", mem_a, a);
        chk("wr_hold_ds", mem_ds, ds);
        chk("wr_hold_d", mem_d, d);
      end
      ctl_tick(rst);
      mem_busy = 1'b0;
      if (!rst) ctl_mem[a[23:3]] = merge(ctl_get(a[23:3]), d, ds);
    end else begin
      for (int i = 0; i < int'(cnt); i++) begin
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          ctl_tick(rst);
          if (rst) begin mem_busy = 1'b0; return; end
        end
        mem_ack = 1'b1;
        mem_q = ctl_get(a[23:3] + 21'(i));
        acks_done++;
        ctl_tick(rst);
        if (rst) begin mem_busy = 1'b0; return; end
      end
      mem_busy = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk); #2;
    if (late_ack_req != late_ack_seen) begin
      late_ack_seen = late_ack_req;
      mem_ack = 1'b1;
      mem_q = 64'hDEAD_BEEF_0BAD_F00D;
      @(posedge clk); #2;
      mem_ack = 1'b0;
    end else if (!reset && mem_req) begin
      serve();
    end
  end

  // ---------------- host read-side driver: 0 hold off, 1 always ready, 2 random
  int rd_mode = 0;
  initial forever begin
    @(posedge clk); #1;
    case (rd_mode)
      0:       rd_ready = 1'b0;
      1:       rd_ready = 1'b1;
      default: rd_ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // ---------------- monitors
  initial begin : req_monitor
    logic prev_req;
    req_t r;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
      end else begin
        if (mem_req) begin
          chk("req_single_cycle", prev_req, 1'b0);
          chk("req_while_busy", mem_busy, 1'b0);
          if (exp_req.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL req_unexpected: got we=%0d cnt=%0d a=%h, required no request",
                     mem_we, mem_burstcnt, mem_a);
          end else begin
            r = exp_req.pop_front();
            chk("req_we", mem_we, r.we);
            chk("req_burstcnt", mem_burstcnt, r.cnt);
            chk("req_addr", mem_a, r.a);
            if (r.we) begin
              chk("req_ds", mem_ds, r.ds);
              chk("req_d", mem_d, r.d);
            end
          end
        end
        prev_req = mem_req;
      end
    end
  end

  initial begin : rd_monitor
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (!reset && rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rd_unexpected: got word %h last=%0d, required none", rd_data, rd_last);
        end else begin
          e = exp_rd.pop_front();
          chk("rd_data", rd_data, e[63:0]);
          chk("rd_last", rd_last, e[64]);
        end
      end
    end
  end

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_last"}, rd_last, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_burstcnt"}, mem_burstcnt, 0);
    chk({tag, "_mem_a"}, mem_a, 0);
    chk({tag, "_mem_ds"}, mem_ds, 0);
    chk({tag, "_mem_d"}, mem_d, 0);
  endtask

  // Watchdog: the run must never hang
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus
  initial begin
    int t, base;
    logic [23:0] a;
    int r;
    logic [7:0] len;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk); #1;
    reset = 1'b0;

    // Short read, host always ready
    rd_mode = 1;
    send_cmd(0, 24'h000100, 8'd4, 8'd0, 64'd0);
    wait_idle("rd4");

    // Read split into 8/8/4
    send_cmd(0, 24'h000200, 8'd20, 8'd0, 64'd0);
    wait_idle("rd20");

    // Host stalled: two full bursts fill the FIFO, the third must wait for credit
    rd_mode = 0;
    base = acks_done;
    send_cmd(0, 24'h000400, 8'd24, 8'd0, 64'd0);
    t = 0;
    while (acks_done < base + 16 && t < 500) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    chk("stall_acks", acks_done - base, 16);
    chk("stall_pending_req", exp_req.size(), 1);
    chk("stall_rd_valid", rd_valid, 1);
    rd_mode = 1;
    wait_idle("stall");

    // Single write with a long busy, then read back across the address wrap
    wr_busy_force = 5;
    send_cmd(1, 24'hFFFFF8, 8'd0, 8'h0F, 64'h1122334455667788);
    t = 0;
    while (!mem_busy && t < 50) begin @(negedge clk); t++; end
    while (mem_busy && t < 100) begin @(negedge clk); t++; end
    chk("wr_busy_seen", (t < 100), 1);
    chk("wr_ready_while_busy_falls", cmd_ready, 0);
    @(negedge clk);
    chk("wr_ready_after_busy", cmd_ready, 1);
    wr_busy_force = 0;
    wait_idle("wr");
    send_cmd(0, 24'hFFFFF8, 8'd2, 8'd0, 64'd0);
    wait_idle("rd_wrap");

    // Zero-length read: no memory access, nothing returned
    send_cmd(0, 24'h000800, 8'd0, 8'd0, 64'd0);
    repeat (4) begin
      @(negedge clk);
      chk("len0_rd_valid", rd_valid, 0);
      chk("len0_mem_req", mem_req, 0);
    end

    // Reset in the middle of an 8-word burst
    rd_mode = 0;
    base = acks_done;
    send_cmd(0, 24'h001000, 8'd8, 8'd0, 64'd0);
    t = 0;
    while (acks_done < base + 2 && t < 200) begin @(negedge clk); t++; end
    chk("mid_two_acks", acks_done - base, 2);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_rd.delete();
    exp_req.delete();
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("mid");
    @(posedge clk); #1;
    reset = 1'b0;
    late_ack_req++;
    repeat (4) begin
      @(negedge clk);
      chk("late_ack_rd_valid", rd_valid, 0);
    end
    rd_mode = 1;
    send_cmd(0, 24'h002000, 8'd5, 8'd0, 64'd0);
    wait_idle("post_reset");

    // Randomized mix with random host back-pressure
    rd_mode = 2;
    for (int k = 0; k < 60; k++) begin
      a = ($urandom_range(0, 1) == 0) ? (24'hFFFF00 + 24'($urandom_range(0, 255)))
                                       : 24'($urandom);
      if ($urandom_range(0, 9) < 3) begin
        send_cmd(1, a, 8'($urandom), 8'($urandom), {$urandom(), $urandom()});
      end else begin
        r = $urandom_range(0, 19);
        len = (r == 0) ? 8'd0 : (r < 17) ? 8'($urandom_range(1, 40)) : 8'($urandom_range(41, 255));
        send_cmd(0, a, len, 8'd0, 64'd0);
      end
    end
    rd_mode = 1;
    wait_idle("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
